// File: rtl/sobel_gradient.sv
// Sobel gradient stage: takes a 3x3 window and produces Gx, Gy and a saturated 8-bit magnitude
// through a 3-stage elastic pipeline. Define SOBEL_THRESHOLD_EN to add the THRESH parameter and edge_o.
module sobel_gradient #(
    parameter int MAG_SHIFT = 0,
    parameter int COUNT_W   = 16
`ifdef SOBEL_THRESHOLD_EN
    ,
    parameter logic [7:0] THRESH = 8'd128
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                window [0:8],
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic signed [10:0]        grad_x,
    output logic signed [10:0]        grad_y,
    output logic [7:0]                magnitude,
    output logic [COUNT_W-1:0]        pix_count
`ifdef SOBEL_THRESHOLD_EN
    ,
    // "edge" is a reserved word, hence the suffixed name.
    output logic                      edge_o
`endif
);

    // Handshake: a stage transfers on valid && ready. A stage is ready when it is empty or its
    // contents leave this cycle; readiness ripples combinationally from out_ready back to in_ready.
    logic s1_ready, s2_ready, s3_ready;
    logic s1_load, s2_load, s3_load, out_xfer;

    // Stage 1: weighted column/row sums
    logic       s1_valid_q, s1_valid_d;
    logic [9:0] l_q, r_q, t_q, b_q;
    logic [9:0] l_d, r_d, t_d, b_d;

    // Stage 2: signed gradients and their magnitudes
    logic               s2_valid_q, s2_valid_d;
    logic signed [10:0] gx_q, gy_q, gx_d, gy_d;
    logic [9:0]         ax_q, ay_q, ax_d, ay_d;

    // Stage 3: output register
    logic               s3_valid_q, s3_valid_d;
    logic signed [10:0] grad_x_q, grad_y_q, grad_x_d, grad_y_d;
    logic [7:0]         mag_q, mag_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic signed [10:0] gx_c, gy_c, ngx_c, ngy_c;
    logic [10:0]        sum_c, shifted_c;
    logic [7:0]         mag_c;

    function automatic logic [9:0] wsum(input logic [7:0] a, input logic [7:0] c, input logic [7:0] e);
        return {2'b00, a} + {1'b0, c, 1'b0} + {2'b00, e};
    endfunction

    assign s3_ready = !s3_valid_q || out_ready;
    assign s2_ready = !s2_valid_q || s3_ready;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign in_ready = s1_ready;

    assign s1_load  = in_valid && s1_ready;
    assign s2_load  = s1_valid_q && s2_ready;
    assign s3_load  = s2_valid_q && s3_ready;
    assign out_xfer = s3_valid_q && out_ready;

    always_comb begin
        gx_c      = $signed({1'b0, r_q}) - $signed({1'b0, l_q});
        gy_c      = $signed({1'b0, b_q}) - $signed({1'b0, t_q});
        ngx_c     = -gx_c;
        ngy_c     = -gy_c;
        sum_c     = {1'b0, ax_q} + {1'b0, ay_q};
        shifted_c = sum_c >> MAG_SHIFT;
        mag_c     = (shifted_c > 11'd255) ? 8'hFF : shifted_c[7:0];
    end

    always_comb begin
        // Valids only depend on handshake signals, so X on an idle window never reaches them.
        s1_valid_d = s1_ready ? in_valid   : s1_valid_q;
        s2_valid_d = s2_ready ? s1_valid_q : s2_valid_q;
        s3_valid_d = s3_ready ? s2_valid_q : s3_valid_q;

        l_d = l_q;
        r_d = r_q;
        t_d = t_q;
        b_d = b_q;
        if (s1_load) begin
            l_d = wsum(window[0], window[3], window[6]);
            r_d = wsum(window[2], window[5], window[8]);
            t_d = wsum(window[0], window[1], window[2]);
            b_d = wsum(window[6], window[7], window[8]);
        end

        gx_d = gx_q;
        gy_d = gy_q;
        ax_d = ax_q;
        ay_d = ay_q;
        if (s2_load) begin
            gx_d = gx_c;
            gy_d = gy_c;
            ax_d = gx_c[10] ? ngx_c[9:0] : gx_c[9:0];
            ay_d = gy_c[10] ? ngy_c[9:0] : gy_c[9:0];
        end

        grad_x_d = grad_x_q;
        grad_y_d = grad_y_q;
        mag_d    = mag_q;
        if (s3_load) begin
            grad_x_d = gx_q;
            grad_y_d = gy_q;
            mag_d    = mag_c;
        end

        count_d = out_xfer ? count_q + COUNT_W'(1) : count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            l_q        <= '0;
            r_q        <= '0;
            t_q        <= '0;
            b_q        <= '0;
            gx_q       <= '0;
            gy_q       <= '0;
            ax_q       <= '0;
            ay_q       <= '0;
            grad_x_q   <= '0;
            grad_y_q   <= '0;
            mag_q      <= '0;
            count_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
            l_q        <= l_d;
            r_q        <= r_d;
            t_q        <= t_d;
            b_q        <= b_d;
            gx_q       <= gx_d;
            gy_q       <= gy_d;
            ax_q       <= ax_d;
            ay_q       <= ay_d;
            grad_x_q   <= grad_x_d;
            grad_y_q   <= grad_y_d;
            mag_q      <= mag_d;
            count_q    <= count_d;
        end
    end

    assign out_valid = s3_valid_q;
    assign grad_x    = grad_x_q;
    assign grad_y    = grad_y_q;
    assign magnitude = mag_q;
    assign pix_count = count_q;

`ifdef SOBEL_THRESHOLD_EN
    // Compared against the saturated magnitude, loaded and held exactly like mag_q.
    logic edge_q, edge_d;

    always_comb begin
        edge_d = edge_q;
        if (s3_load) begin
            edge_d = (mag_c >= THRESH);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_q <= 1'b0;
        end else begin
            edge_q <= edge_d;
        end
    end

    assign edge_o = edge_q;
`endif

endmodule
